// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes and byte-wide RAM port of the memory arbiter
interface mem_arbiter_if #(parameter int ADDR_W = 17);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_flush;
    logic              if_done;
    logic [31:0]       if_inst;
    logic              mem_req;
    logic              mem_we;
    logic [2:0]        mem_func3;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;
    logic              stallreq_if;
    logic              stallreq_mem;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;
    modport slave (
        input  if_req, if_addr, if_flush, mem_req, mem_we, mem_func3, mem_addr, mem_wdata, ram_din,
        output if_done, if_inst, mem_done, mem_rdata, stallreq_if, stallreq_mem, ram_a, ram_wr, ram_dout
    );
    modport master (
        output if_req, if_addr, if_flush, mem_req, mem_we, mem_func3, mem_addr, mem_wdata, ram_din,
        input  if_done, if_inst, mem_done, mem_rdata, stallreq_if, stallreq_mem, ram_a, ram_wr, ram_dout
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IF fetches and MEM loads/stores onto a byte-wide synchronous RAM
module mem_arbiter #(
    parameter int ADDR_W = 17
) (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t            state_q, state_d;
    logic              own_if_q, own_if_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic [2:0]        f3_q, f3_d;
    logic [2:0]        n_q, n_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [31:0]       if_inst_q, if_inst_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic [31:0]       word;
    logic              unused_addr_hi;

    function automatic logic [31:0] ext(input logic [2:0] f, input logic [31:0] w);
        return f == 3'b000 ? {{24{w[7]}}, w[7:0]} :
               f == 3'b001 ? {{16{w[15]}}, w[15:0]} :
               f == 3'b100 ? {24'b0, w[7:0]} :
               f == 3'b101 ? {16'b0, w[15:0]} : w;
    endfunction

    function automatic logic [2:0] len_of(input logic [2:0] f);
        return f[1] ? 3'd4 : f[0] ? 3'd2 : 3'd1;
    endfunction

    // ram_din in READ cycle cnt holds byte cnt-1 (one-cycle RAM latency)
    assign word = buf_q | (32'(bus.ram_din) << {cnt_q - 3'd1, 3'b000});

    assign unused_addr_hi = ^{bus.if_addr[31:ADDR_W], bus.mem_addr[31:ADDR_W]};

    always_comb begin
        state_d     = state_q;
        own_if_d    = own_if_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        f3_d        = f3_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.mem_req) begin
                    own_if_d = 1'b0;
                    base_d   = bus.mem_addr[ADDR_W-1:0];
                    wdata_d  = bus.mem_wdata;
                    f3_d     = bus.mem_func3;
                    n_d      = len_of(bus.mem_func3);
                    cnt_d    = '0;
                    buf_d    = '0;
                    state_d  = bus.mem_we ? WRITE : READ;
                end else if (bus.if_req && !bus.if_flush) begin
                    own_if_d = 1'b1;
                    base_d   = bus.if_addr[ADDR_W-1:0];
                    f3_d     = 3'b010;
                    n_d      = 3'd4;
                    cnt_d    = '0;
                    buf_d    = '0;
                    state_d  = READ;
                end
            end
            READ: begin
                if (own_if_q && bus.if_flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q != 3'd0) buf_d = word;
                    if (cnt_q == n_q) begin
                        state_d     = DONE;
                        if_done_d   = own_if_q;
                        mem_done_d  = !own_if_q;
                        if_inst_d   = own_if_q ? word : if_inst_q;
                        mem_rdata_d = own_if_q ? mem_rdata_q : ext(f3_q, word);
                    end
                end
            end
            WRITE: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == n_q - 3'd1) begin
                    state_d    = DONE;
                    mem_done_d = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            own_if_q    <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            f3_q        <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            own_if_q    <= own_if_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            f3_q        <= f3_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // the final READ cycle only collects the last byte, so the address bus idles
    assign bus.ram_a        = ((state_q == READ && cnt_q != n_q) || state_q == WRITE) ?
                              base_q + ADDR_W'(cnt_q) : '0;
    assign bus.ram_wr       = state_q == WRITE;
    assign bus.ram_dout     = state_q == WRITE ? 8'(wdata_q >> {cnt_q[1:0], 3'b000}) : '0;
    assign bus.if_done      = if_done_q;
    assign bus.mem_done     = mem_done_q;
    assign bus.if_inst      = if_inst_q;
    assign bus.mem_rdata    = mem_rdata_q;
    assign bus.stallreq_if  = bus.if_req & ~if_done_q;
    assign bus.stallreq_mem = bus.mem_req & ~mem_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector bench for mem_arbiter with a byte RAM model
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(17)) bus();
    mem_arbiter #(.ADDR_W(17)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0]  ram [0:131071];
    logic        pl_we;
    logic [16:0] pl_a;
    logic [7:0]  pl_d;

    always @(posedge clk) begin
        bus.ram_din <= ram[bus.ram_a];
        if (pl_we) ram[pl_a] <= pl_d;
        else if (bus.ram_wr) ram[bus.ram_a] <= bus.ram_dout;
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs [14];
    int          tests = 0;
    int          fails = 0;
    logic [16:0] alog [0:31];
    logic        wlog [0:31];
    logic [7:0]  dlog [0:31];
    int          lat, k, kmem, kif, cnt;
    logic        sbad;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic poke(input logic [16:0] a, input logic [7:0] d);
        pl_we = 1'b1;
        pl_a  = a;
        pl_d  = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic run(input logic is_if, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, output int l);
        @(negedge clk);
        if (is_if) begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end else begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = we;
            bus.mem_func3 = f3;
            bus.mem_addr  = addr;
            bus.mem_wdata = wdata;
        end
        l = 0;
        do begin
            @(negedge clk);
            l++;
            alog[l] = bus.ram_a;
            wlog[l] = bus.ram_wr;
            dlog[l] = bus.ram_dout;
        end while (!(is_if ? bus.if_done : bus.mem_done) && l < 30);
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 3'b000, 32'h20, 32'h0, 32'hFFFFFF80, 3};
        vecs[1]  = '{1'b0, 3'b100, 32'h20, 32'h0, 32'h00000080, 3};
        vecs[2]  = '{1'b0, 3'b001, 32'h20, 32'h0, 32'h00001280, 4};
        vecs[3]  = '{1'b0, 3'b101, 32'h22, 32'h0, 32'h0000F134, 4};
        vecs[4]  = '{1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFFF134, 4};
        vecs[5]  = '{1'b0, 3'b010, 32'h20, 32'h0, 32'hF1341280, 6};
        vecs[6]  = '{1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 6};
        vecs[7]  = '{1'b1, 3'b000, 32'h50, 32'h123456AA, 32'h0, 2};
        vecs[8]  = '{1'b0, 3'b010, 32'h50, 32'h0, 32'h000000AA, 6};
        vecs[9]  = '{1'b1, 3'b001, 32'h60, 32'h1234ABCD, 32'h0, 3};
        vecs[10] = '{1'b0, 3'b001, 32'h60, 32'h0, 32'hFFFFABCD, 4};
        vecs[11] = '{1'b0, 3'b011, 32'h40, 32'h0, 32'hDEADBEEF, 6};
        vecs[12] = '{1'b0, 3'b101, 32'h41, 32'h0, 32'h0000ADBE, 4};
        vecs[13] = '{1'b0, 3'b111, 32'h20, 32'h0, 32'hF1341280, 6};

        bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
        bus.mem_req = 0; bus.mem_we = 0; bus.mem_func3 = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
        pl_we = 0; pl_a = 0; pl_d = 0;
        @(negedge clk);
        poke(17'h00020, 8'h80); poke(17'h00021, 8'h12); poke(17'h00022, 8'h34); poke(17'h00023, 8'hF1);
        poke(17'h00100, 8'h13); poke(17'h00101, 8'h05); poke(17'h00102, 8'h00); poke(17'h00103, 8'h00);
        poke(17'h00200, 8'h78); poke(17'h00201, 8'h56); poke(17'h00202, 8'h34); poke(17'h00203, 8'h12);
        poke(17'h1FFFF, 8'h01); poke(17'h00000, 8'h02); poke(17'h00001, 8'h03); poke(17'h00002, 8'h04);
        poke(17'h00051, 8'h00); poke(17'h00052, 8'h00); poke(17'h00053, 8'h00);

        check("reset_flags", {27'b0, bus.if_done, bus.mem_done, bus.ram_wr, bus.stallreq_if, bus.stallreq_mem}, 32'h0);
        check("reset_inst", bus.if_inst, 32'h0);
        check("reset_rdata", bus.mem_rdata, 32'h0);
        check("reset_ram", {7'b0, bus.ram_a, bus.ram_dout}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, lat);
        check("fetch_lat", 32'(lat), 32'd6);
        check("fetch_inst", bus.if_inst, 32'h00000513);
        for (int i = 0; i < 4; i++) check("fetch_addr", 32'(alog[i+1]), 32'h100 + 32'(i));

        run(1'b0, 1'b1, 3'b010, 32'h40, 32'hDEADBEEF, lat);
        check("sw_lat", 32'(lat), 32'd5);
        check("sw_b0", {6'b0, wlog[1], alog[1], dlog[1]}, {6'b0, 1'b1, 17'h40, 8'hEF});
        check("sw_b1", {6'b0, wlog[2], alog[2], dlog[2]}, {6'b0, 1'b1, 17'h41, 8'hBE});
        check("sw_b2", {6'b0, wlog[3], alog[3], dlog[3]}, {6'b0, 1'b1, 17'h42, 8'hAD});
        check("sw_b3", {6'b0, wlog[4], alog[4], dlog[4]}, {6'b0, 1'b1, 17'h43, 8'hDE});
        check("sw_done_nowr", {31'b0, wlog[5]}, 32'h0);

        for (int i = 0; i < 14; i++) begin
            run(1'b0, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), bus.mem_rdata, vecs[i].exp);
        end

        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_func3 = 3'b010; bus.mem_addr = 32'h20;
        k = 0; kmem = 0; kif = 0; sbad = 1'b0;
        while (kif == 0 && k < 40) begin
            @(negedge clk);
            k++;
            if (bus.mem_done) begin kmem = k; bus.mem_req = 1'b0; end
            if (bus.if_done) begin kif = k; bus.if_req = 1'b0; end
            else if (bus.stallreq_if !== 1'b1) sbad = 1'b1;
        end
        check("both_mem_lat", 32'(kmem), 32'd6);
        check("both_if_lat", 32'(kif), 32'd13);
        check("both_stall_if", {31'b0, sbad}, 32'h0);
        check("both_rdata", bus.mem_rdata, 32'hF1341280);
        check("both_inst", bus.if_inst, 32'h00000513);

        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        @(negedge clk);
        @(negedge clk);
        bus.if_flush = 1'b1; bus.if_req = 1'b0;
        @(negedge clk);
        bus.if_flush = 1'b0;
        check("flush_idle", {14'b0, bus.ram_wr, bus.ram_a}, 32'h0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.if_done) cnt++;
            @(negedge clk);
        end
        check("flush_no_done", 32'(cnt), 32'd0);
        check("flush_inst_hold", bus.if_inst, 32'h00000513);
        run(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, lat);
        check("refetch_lat", 32'(lat), 32'd6);
        check("refetch_inst", bus.if_inst, 32'h12345678);

        @(negedge clk);
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_func3 = 3'b010;
        bus.mem_addr = 32'h70; bus.mem_wdata = 32'h11223344;
        repeat (3) @(negedge clk);
        check("rstmid_b2", {6'b0, bus.ram_wr, bus.ram_a, bus.ram_dout}, {6'b0, 1'b1, 17'h72, 8'h22});
        rst = 1'b1; bus.mem_req = 1'b0;
        @(negedge clk);
        check("rstmid_flags", {27'b0, bus.if_done, bus.mem_done, bus.ram_wr, bus.stallreq_if, bus.stallreq_mem}, 32'h0);
        check("rstmid_ram", {7'b0, bus.ram_a, bus.ram_dout}, 32'h0);
        check("rstmid_data", bus.if_inst | bus.mem_rdata, 32'h0);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.mem_done) cnt++;
        end
        check("rstmid_no_done", 32'(cnt), 32'd0);

        run(1'b0, 1'b0, 3'b010, 32'h0001FFFF, 32'h0, lat);
        check("wrap_lat", 32'(lat), 32'd6);
        check("wrap_a0", 32'(alog[1]), 32'h1FFFF);
        check("wrap_a1", 32'(alog[2]), 32'h00000);
        check("wrap_a2", 32'(alog[3]), 32'h00001);
        check("wrap_a3", 32'(alog[4]), 32'h00002);
        check("wrap_rdata", bus.mem_rdata, 32'h04030201);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-owner controller for the byte-wide synchronous RAM port, shared by two requesters: instruction fetch (IF) and the MEM-stage load/store path fed from the EX/MEM register.
- Serialises multi-byte accesses into byte cycles, assembles and sign-extends load data, and returns one-cycle done pulses.
- Drives the IF and MEM stall requests consumed by the pipeline stall controller.

Parameters:
- ADDR_W, 17, width of the RAM byte address; upper request-address bits are ignored.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request, held until if_done or if_flush
- if_addr  in  32  fetch byte address
- if_flush  in  1  abort any pending or in-flight fetch (branch taken)
- if_done  out  1  one-cycle pulse: if_inst is valid
- if_inst  out  32  fetched word, little-endian
- mem_req  in  1  load/store request, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_func3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- mem_addr  in  32  data byte address
- mem_wdata  in  32  store data; low bytes used
- mem_done  out  1  one-cycle pulse: access complete, mem_rdata valid for loads
- mem_rdata  out  32  load result, sign- or zero-extended per func3
- stallreq_if  out  1  if_req & ~if_done (combinational)
- stallreq_mem  out  1  mem_req & ~mem_done (combinational)
- ram_a  out  ADDR_W  RAM byte address
- ram_wr  out  1  RAM write strobe
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte, valid the cycle after its address

Behaviour:
- Reset:
  - all outputs 0; state IDLE; counters 0.
  - Reset mid-access abandons it: no done pulse, and ram_wr is 0 from the next edge.
- States: IDLE, READ, WRITE, DONE.
- Access length N from func3:
  - B/BU = 1; H/HU = 2; W and undefined encodings = 4.
  - IF accesses are always N = 4.
- IDLE:
  - If mem_req, latch mem_* and go to READ or WRITE according to mem_we.
  - Else if if_req & ~if_flush, latch if_addr and go to READ (owner = IF).
  - MEM has fixed priority over IF.
  - ram_a = 0, ram_wr = 0, ram_dout = 0.
- Acceptance cycle: call the cycle in which IDLE accepts a request T.
- READ:
  - Cycles T+1..T+N drive ram_a = (base + i)[ADDR_W-1:0], i = 0..N-1.
  - Byte i is captured from ram_din at the end of cycle T+2+i into bits [8i+7:8i].
  - READ lasts N+1 cycles, then DONE. Addresses wrap within ADDR_W bits.
- WRITE:
  - Cycles T+1..T+N drive ram_wr = 1, ram_a = base + i, ram_dout = wdata[8i+7:8i].
  - Then DONE; no read-back.
- DONE (one cycle):
  - The owner's done output is 1; registered, so it is a registered output in this cycle.
  - mem_rdata: B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W is passed through.
  - if_inst / mem_rdata update only on their own completion and hold otherwise.
  - No request is accepted in DONE, so a requester still holding req is never served twice; next state is IDLE.
- Latency from acceptance cycle T to done cycle:
  - load N+2 cycles;
  - store N+1 cycles;
  - fetch 6 cycles.
  - Minimum gap between back-to-back accesses: 1 IDLE cycle.
- if_flush:
  - If asserted while IF owns READ, the access aborts: next state IDLE, no if_done, if_inst unchanged.
  - If asserted in IDLE, any if_req that cycle is ignored.
  - Flush never affects a MEM-owned access.
  - If flush coincides with the IF DONE cycle, if_done is still issued and IF ignores it.
- Simultaneous requests in IDLE: MEM is served; the IF request stays pending and stallreq_if stays 1.
- mem_req or if_req deasserting mid-access, except via if_flush, is illegal; the access completes regardless.

Test Plan:
- Reset, then if_req, if_addr = 0x100, RAM[0x100..0x103] = 13 05 00 00 -> if_done 6 cycles after acceptance, if_inst = 0x00000513; ram_a sequence 0x100..0x103.
- Load LB at 0x20 where RAM = 0x80 -> mem_rdata = 0xFFFFFF80; the same byte loaded with LBU -> 0x00000080; LH at 0x20 with RAM 0x80,0x12 -> 0x00001280.
- Store SW 0xDEADBEEF at 0x40 -> ram_wr high for 4 consecutive cycles, ram_dout EF, BE, AD, DE at 0x40..0x43; mem_done in cycle T+5.
- if_req and mem_req (LW) asserted in the same IDLE cycle -> MEM served first with stallreq_if = 1 throughout; fetch accepted in the IDLE cycle after mem_done; IF completes correctly.
- if_flush asserted two cycles into a fetch -> state IDLE next cycle, no if_done, if_inst unchanged; new fetch to 0x200 then completes normally.
- rst asserted during the third byte of an SW -> next cycle ram_wr = 0, all outputs 0, no mem_done; address 0x1FFFF + 3 on W load wraps to ram_a 0x00002.
